// File: rtl/alu_pm_pkg.sv
// alu_pm_pkg: shared definitions for the ALU power-management slice.
//   pm_state_e : power-sequencer FSM state with fixed legacy encodings
//   CNT_W      : width of the 16-bit idle and wake counters
package alu_pm_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_PWR_UP  = 3'd1,
    S_ON      = 3'd2,
    S_DRAIN   = 3'd3,
    S_ISO_SET = 3'd4
  } pm_state_e;

endpackage

// File: rtl/pm_timer.sv
// pm_timer: loadable 8-bit down-counter used for the power-up and
// isolation-setup delays.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over counting)
//   load_val   : value to load
//   en         : count down by one per cycle while non-zero
//   done       : counter is at zero
module pm_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/alu_pwr_ctrl.sv
// alu_pwr_ctrl: power sequencer for the power-gated ALU domain.
// Orders power/isolation (power up, then release isolation; isolate, then
// power down), gates operation starts, and powers down on idle.
//   clk, rst_n   : clock, asynchronous active-low reset
//   wake_req     : level request to power the ALU
//   sleep_req    : level request to power down / hold off
//   op_req       : requester wants to issue an operation
//   alu_busy     : ALU busy flag
//   op_gnt       : operation accepted this cycle (combinational)
//   alu_start    : start pulse to the ALU (same as op_gnt)
//   alu_pwr_en   : ALU power switch enable
//   iso_en       : ALU output isolation
//   ready        : powered, de-isolated and accepting operations
//   state        : current FSM state (debug)
//   wake_cnt     : completed power-ups, saturating
module alu_pwr_ctrl
  import alu_pm_pkg::*;
#(
  parameter int unsigned PWR_UP_CYC    = 8,
  parameter int unsigned ISO_SETUP_CYC = 2,
  parameter int unsigned IDLE_TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wake_req,
  input  logic             sleep_req,
  input  logic             op_req,
  input  logic             alu_busy,
  output logic             op_gnt,
  output logic             alu_start,
  output logic             alu_pwr_en,
  output logic             iso_en,
  output logic             ready,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] wake_cnt
);

  // The timer is loaded with N-1 on entry so that done is seen in the
  // N-th cycle of the state and the exit edge is exactly N cycles later.
  localparam logic [7:0]       PWR_UP_LD = 8'(PWR_UP_CYC - 1);
  localparam logic [7:0]       ISO_LD    = 8'(ISO_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
  localparam bit               IDLE_EN   = (IDLE_TIMEOUT != 0);

  pm_state_e        state_q, state_d;
  logic [CNT_W-1:0] idle_q;
  logic [CNT_W-1:0] wake_cnt_q;
  logic             tmr_load, tmr_done, tmr_en;
  logic [7:0]       tmr_val;
  logic             grant, idle_hit;

  assign grant = op_req & (state_q == S_ON) & ~alu_busy & ~sleep_req;

  // Fires in the cycle whose closing edge would bring the idle count to
  // IDLE_TIMEOUT, so DRAIN is entered exactly IDLE_TIMEOUT idle cycles on.
  assign idle_hit = IDLE_EN && (idle_q == IDLE_LAST) && !alu_busy && !grant;

  assign tmr_en = (state_q == S_PWR_UP) || (state_q == S_ISO_SET);

  pm_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = PWR_UP_LD;
    case (state_q)
      S_OFF: begin
        if ((wake_req || op_req) && !sleep_req) begin
          state_d  = S_PWR_UP;
          tmr_load = 1'b1;
          tmr_val  = PWR_UP_LD;
        end
      end
      S_PWR_UP: begin
        if (tmr_done) state_d = S_ON;
      end
      S_ON: begin
        if (sleep_req || idle_hit) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!alu_busy) begin
          state_d  = S_ISO_SET;
          tmr_load = 1'b1;
          tmr_val  = ISO_LD;
        end
      end
      S_ISO_SET: begin
        if (tmr_done) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else if ((state_q != S_ON) || grant || alu_busy) begin
      idle_q <= '0;
    end else if (idle_q != '1) begin
      idle_q <= idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wake_cnt_q <= '0;
    end else if ((state_q == S_PWR_UP) && tmr_done && (wake_cnt_q != '1)) begin
      wake_cnt_q <= wake_cnt_q + 1'b1;
    end
  end

  always_comb begin
    alu_pwr_en = 1'b0;
    iso_en     = 1'b1;
    ready      = 1'b0;
    case (state_q)
      S_PWR_UP:  begin alu_pwr_en = 1'b1; iso_en = 1'b1; end
      S_ON:      begin alu_pwr_en = 1'b1; iso_en = 1'b0; ready = 1'b1; end
      S_DRAIN:   begin alu_pwr_en = 1'b1; iso_en = 1'b0; end
      S_ISO_SET: begin alu_pwr_en = 1'b1; iso_en = 1'b1; end
      default:   begin alu_pwr_en = 1'b0; iso_en = 1'b1; end
    endcase
  end

  assign op_gnt    = grant;
  assign alu_start = grant;
  assign state     = state_q;
  assign wake_cnt  = wake_cnt_q;

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// tb_alu_pwr_ctrl: scoreboard bench for alu_pwr_ctrl. Stimulus pushes
// expected snapshots (keyed by cycle) and expected grant cycles; a monitor
// compares them at the falling edge. A second instance with IDLE_TIMEOUT=0
// shares all inputs.
module tb_alu_pwr_ctrl;
  import alu_pm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wake_req = 1'b0, sleep_req = 1'b0, op_req = 1'b0, alu_busy = 1'b0;
  logic        op_gnt, alu_start, alu_pwr_en, iso_en, ready;
  logic [2:0]  state;
  logic [15:0] wake_cnt;
  logic        op_gnt0, alu_start0, alu_pwr_en0, iso_en0, ready0;
  logic [2:0]  state0;
  logic [15:0] wake_cnt0;

  alu_pwr_ctrl #(.PWR_UP_CYC(8), .ISO_SETUP_CYC(2), .IDLE_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .wake_req(wake_req), .sleep_req(sleep_req),
    .op_req(op_req), .alu_busy(alu_busy), .op_gnt(op_gnt), .alu_start(alu_start),
    .alu_pwr_en(alu_pwr_en), .iso_en(iso_en), .ready(ready), .state(state),
    .wake_cnt(wake_cnt)
  );

  alu_pwr_ctrl #(.PWR_UP_CYC(8), .ISO_SETUP_CYC(2), .IDLE_TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wake_req(wake_req), .sleep_req(sleep_req),
    .op_req(op_req), .alu_busy(alu_busy), .op_gnt(op_gnt0), .alu_start(alu_start0),
    .alu_pwr_en(alu_pwr_en0), .iso_en(iso_en0), .ready(ready0), .state(state0),
    .wake_cnt(wake_cnt0)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  st;
    logic        gnt;
    logic [15:0] wc;
    logic [2:0]  st0;
  } snap_t;

  snap_t       snap_q[$];
  int unsigned gnt_q[$];
  int          nvec = 0;
  int          nfail = 0;

  // {alu_pwr_en, iso_en, ready} for each state, from the output table.
  function automatic logic [2:0] moore(input logic [2:0] st);
    case (st)
      3'd0:    return 3'b010;
      3'd1:    return 3'b110;
      3'd2:    return 3'b101;
      3'd3:    return 3'b100;
      3'd4:    return 3'b110;
      default: return 3'bxxx;
    endcase
  endfunction

  task automatic exp_at(input int unsigned k, input logic [2:0] st, input logic gnt,
                        input logic [15:0] wc, input logic [2:0] st0);
    snap_t s;
    s.cyc = cyc + k; s.st = st; s.gnt = gnt; s.wc = wc; s.st0 = st0;
    snap_q.push_back(s);
  endtask

  task automatic exp_gnt(input int unsigned k);
    gnt_q.push_back(cyc + k);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    snap_t s;
    int unsigned g;
    forever begin
      @(negedge clk);
      if (op_gnt) begin
        nvec++;
        if (gnt_q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_gnt: cycle %0d got op_gnt=1 required 0", cyc);
        end else begin
          g = gnt_q.pop_front();
          if (g != cyc || alu_start !== 1'b1) begin
            nfail++;
            $display("FAIL gnt_timing: got gnt at cycle %0d alu_start=%b, required cycle %0d alu_start=1",
                     cyc, alu_start, g);
          end
        end
      end
      while (snap_q.size() != 0 && snap_q[0].cyc <= cyc) begin
        s = snap_q.pop_front();
        nvec++;
        if (s.cyc != cyc || state !== s.st || {alu_pwr_en, iso_en, ready} !== moore(s.st) ||
            op_gnt !== s.gnt || alu_start !== s.gnt || wake_cnt !== s.wc ||
            state0 !== s.st0 || {alu_pwr_en0, iso_en0, ready0} !== moore(s.st0)) begin
          nfail++;
          $display("FAIL snap@%0d: got cyc=%0d st=%0d pwr/iso/rdy=%b gnt=%b start=%b wc=%h st0=%0d p/i/r0=%b; required st=%0d pwr/iso/rdy=%b gnt=%b wc=%h st0=%0d p/i/r0=%b",
                   s.cyc, cyc, state, {alu_pwr_en, iso_en, ready}, op_gnt, alu_start, wake_cnt,
                   state0, {alu_pwr_en0, iso_en0, ready0},
                   s.st, moore(s.st), s.gnt, s.wc, s.st0, moore(s.st0));
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state, then wake: power on after edge 0, ready after edge 8.
    exp_at(0, S_OFF, 0, 16'd0, S_OFF);
    wake_req = 1'b1;
    exp_at(1, S_PWR_UP, 0, 16'd0, S_PWR_UP);
    exp_at(8, S_PWR_UP, 0, 16'd0, S_PWR_UP);
    exp_at(9, S_ON,     0, 16'd1, S_ON);
    tick(9);
    wake_req = 1'b0;

    // Grant gated by busy, then granted the cycle busy drops.
    op_req = 1'b1; alu_busy = 1'b1;
    exp_at(0, S_ON, 0, 16'd1, S_ON);
    tick(1);
    exp_at(0, S_ON, 0, 16'd1, S_ON);
    tick(1);
    alu_busy = 1'b0;
    exp_gnt(0);
    exp_at(0, S_ON, 1, 16'd1, S_ON);
    tick(1);

    // op_req still high plus sleep_req: sleep wins, no grant; then
    // sleep_req holds the domain off despite op_req.
    sleep_req = 1'b1;
    exp_at(0, S_ON,      0, 16'd1, S_ON);
    exp_at(1, S_DRAIN,   0, 16'd1, S_DRAIN);
    exp_at(2, S_ISO_SET, 0, 16'd1, S_ISO_SET);
    exp_at(3, S_ISO_SET, 0, 16'd1, S_ISO_SET);
    exp_at(4, S_OFF,     0, 16'd1, S_OFF);
    exp_at(6, S_OFF,     0, 16'd1, S_OFF);
    tick(6);

    // op_req from OFF auto-wakes; grant lands 9 cycles after the request.
    sleep_req = 1'b0;
    exp_at(1, S_PWR_UP, 0, 16'd1, S_PWR_UP);
    exp_at(8, S_PWR_UP, 0, 16'd1, S_PWR_UP);
    exp_gnt(9);
    exp_at(9, S_ON, 1, 16'd2, S_ON);
    tick(10);

    // Sleep with busy high for 5 cycles, wake during ISO_SET.
    op_req = 1'b0; alu_busy = 1'b1; sleep_req = 1'b1;
    exp_at(0, S_ON, 0, 16'd2, S_ON);
    for (int unsigned k = 1; k <= 5; k++) exp_at(k, S_DRAIN, 0, 16'd2, S_DRAIN);
    exp_at(6, S_ISO_SET, 0, 16'd2, S_ISO_SET);
    exp_at(7, S_ISO_SET, 0, 16'd2, S_ISO_SET);
    exp_at(8, S_OFF,     0, 16'd2, S_OFF);
    exp_at(9, S_PWR_UP,  0, 16'd2, S_PWR_UP);
    tick(5);
    alu_busy = 1'b0;
    tick(1);
    sleep_req = 1'b0; wake_req = 1'b1;
    tick(4);

    // Asynchronous reset in the middle of PWR_UP.
    rst_n = 1'b0; wake_req = 1'b0;
    exp_at(0, S_OFF, 0, 16'd0, S_OFF);
    tick(2);
    rst_n = 1'b1;

    // Idle timeout: DRAIN 64 cycles after ON entry; IDLE_TIMEOUT=0 stays ON.
    exp_at(0, S_OFF, 0, 16'd0, S_OFF);
    wake_req = 1'b1;
    exp_at(1,    S_PWR_UP,  0, 16'd0, S_PWR_UP);
    exp_at(9,    S_ON,      0, 16'd1, S_ON);
    exp_at(72,   S_ON,      0, 16'd1, S_ON);
    exp_at(73,   S_DRAIN,   0, 16'd1, S_ON);
    exp_at(74,   S_ISO_SET, 0, 16'd1, S_ON);
    exp_at(76,   S_OFF,     0, 16'd1, S_ON);
    exp_at(1009, S_OFF,     0, 16'd1, S_ON);
    tick(1);
    wake_req = 1'b0;
    tick(1009);

    // Saturation: preload the wake counter one below its limit.
    force dut.wake_cnt_q = 16'hFFFE;
    #1 release dut.wake_cnt_q;
    exp_at(0, S_OFF, 0, 16'hFFFE, S_ON);
    wake_req = 1'b1;
    exp_at(1, S_PWR_UP, 0, 16'hFFFE, S_ON);
    exp_at(9, S_ON,     0, 16'hFFFF, S_ON);
    tick(9);
    wake_req = 1'b0; sleep_req = 1'b1;
    exp_at(1, S_DRAIN,   0, 16'hFFFF, S_DRAIN);
    exp_at(2, S_ISO_SET, 0, 16'hFFFF, S_ISO_SET);
    exp_at(4, S_OFF,     0, 16'hFFFF, S_OFF);
    tick(4);
    sleep_req = 1'b0; wake_req = 1'b1;
    exp_at(1, S_PWR_UP, 0, 16'hFFFF, S_PWR_UP);
    exp_at(9, S_ON,     0, 16'hFFFF, S_ON);
    tick(10);
    wake_req = 1'b0;
    tick(2);

    if (snap_q.size() != 0) begin
      nvec++; nfail++;
      $display("FAIL snap_drain: %0d snapshots left unchecked, required 0", snap_q.size());
    end
    if (gnt_q.size() != 0) begin
      nvec++; nfail++;
      $display("FAIL gnt_missing: %0d expected grants not seen, required 0", gnt_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
